uart_frame_tx: RTL and testbench

Synthesizable, parametrised UART frame transmitter with an input FIFO. Successor to the fixed-format 8-bit serial stimulus used against `top_sub`. It supports configurable data width, bit order, parity, stop bits, inter-frame gap, and a fractional clocks-per-bit divisor (for example 271 5/16). Sits between a byte/word producer (loader, DMA, or bench) and a `UART_RX`-style serial line.

---
 rtl/uart_frame_tx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// uart_frame_tx : UART frame transmitter with input FIFO and fractional divisor
// Optional break generator enabled by defining UART_FRAME_TX_BREAK_EN.
// Revision      : 1.0
// ============================================================================
module uart_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_AW    = 4,
    parameter int DIV_INT    = 271,
    parameter int DIV_FRAC   = 5,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              en,
`ifdef UART_FRAME_TX_BREAK_EN
    input  logic              break_req,
`endif
    output logic              UART_TX,
    output logic              busy,
    output logic [FIFO_AW:0]  fifo_count
);

    localparam int DEPTH  = 2**FIFO_AW;
    localparam int N_BITS = 1 + DATA_W + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int CNT_W  = $clog2(DIV_INT + GAP_CYCLES + 2);
    localparam int BIT_W  = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
`ifdef UART_FRAME_TX_BREAK_EN
    localparam logic [2:0] ST_BRK   = 3'd6;
`endif

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [DATA_W-1:0]  w_head;
    logic               w_push;
    logic               w_pop;

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bits;
    logic [3:0]         r_acc;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;

    logic [4:0]         w_sum;
    logic [CNT_W-1:0]   w_period;
    logic               w_last;
    logic               w_head_bit;
    logic [DATA_W-1:0]  w_shift_next;

    assign in_ready = (fifo_count != (FIFO_AW+1)'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];
    assign busy     = (r_state != ST_IDLE);

`ifdef UART_FRAME_TX_BREAK_EN
    assign w_pop = (r_state == ST_IDLE) && en && (fifo_count != '0) && !break_req;
`else
    assign w_pop = (r_state == ST_IDLE) && en && (fifo_count != '0);
`endif

    // The accumulator restarts from zero on every frame/break entry out of IDLE.
    assign w_sum    = {1'b0, ((r_state == ST_IDLE) ? 4'd0 : r_acc)} + 5'(DIV_FRAC);
    assign w_period = CNT_W'(DIV_INT) + CNT_W'(w_sum[4]);
    assign w_last   = (r_cnt == CNT_W'(1));

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_head_bit   = r_shift[DATA_W-1];
            assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_bit   = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!w_push && w_pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // The line flop is loaded with the next bit's level at each period boundary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            UART_TX <= 1'b1;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_acc   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
`ifdef UART_FRAME_TX_BREAK_EN
            if (break_req) begin
                r_state <= ST_BRK;
                UART_TX <= 1'b0;
                r_bits  <= BIT_W'(2 * N_BITS);
                r_cnt   <= w_period;
                r_acc   <= w_sum[3:0];
            end else
`endif
            if (w_pop) begin
                r_state <= ST_START;
                UART_TX <= 1'b0;
                r_shift <= w_head;
                r_par   <= (^w_head) ^ (PARITY == 2);
                r_cnt   <= w_period;
                r_acc   <= w_sum[3:0];
            end
        end else if (!w_last) begin
            r_cnt <= r_cnt - 1'b1;
        end else begin
            r_cnt <= w_period;
            r_acc <= w_sum[3:0];
            case (r_state)
                ST_START: begin
                    r_state <= ST_DATA;
                    UART_TX <= w_head_bit;
                    r_shift <= w_shift_next;
                    r_bits  <= BIT_W'(DATA_W);
                end
                ST_DATA: begin
                    if (r_bits == BIT_W'(1)) begin
                        if (PARITY != 0) begin
                            r_state <= ST_PAR;
                            UART_TX <= r_par;
                        end else begin
                            r_state <= ST_STOP;
                            UART_TX <= 1'b1;
                            r_bits  <= BIT_W'(STOP_BITS);
                        end
                    end else begin
                        r_bits  <= r_bits - 1'b1;
                        UART_TX <= w_head_bit;
                        r_shift <= w_shift_next;
                    end
                end
                ST_PAR: begin
                    r_state <= ST_STOP;
                    UART_TX <= 1'b1;
                    r_bits  <= BIT_W'(STOP_BITS);
                end
                ST_STOP: begin
                    if (r_bits == BIT_W'(1)) begin
                        if (GAP_CYCLES > 0) begin
                            r_state <= ST_GAP;
                            r_cnt   <= CNT_W'(GAP_CYCLES);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_bits <= r_bits - 1'b1;
                    end
                end
`ifdef UART_FRAME_TX_BREAK_EN
                ST_BRK: begin
                    if (r_bits == BIT_W'(1)) begin
                        r_state <= ST_IDLE;
                        UART_TX <= 1'b1;
                    end else begin
                        r_bits <= r_bits - 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    UART_TX <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_frame_tx : directed bench for uart_frame_tx, frames checked bit by bit
// against a scoreboard of pushed words. Revision: 1.0
// ============================================================================
module tb_uart_frame_tx;

    localparam int P_DIVI [4] = '{271, 5, 4, 8};
    localparam int P_DIVF [4] = '{5,   7, 0, 0};
    localparam int P_MSB  [4] = '{1,   0, 0, 1};
    localparam int P_PAR  [4] = '{0,   1, 2, 0};
    localparam int P_STOP [4] = '{1,   2, 1, 1};
    localparam int P_GAP  [4] = '{0,   0, 3, 0};
`ifdef UART_FRAME_TX_BREAK_EN
    localparam int NI = 4;
`else
    localparam int NI = 3;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [7:0] din [4];
    logic       vld [4];
    logic       en  [4];
    logic       tx0, tx1, tx2, rdy0, rdy1, rdy2, busy0, busy1, busy2;
    logic [4:0] fc0, fc2;
    logic [2:0] fc1;
`ifdef UART_FRAME_TX_BREAK_EN
    logic       tx3, rdy3, busy3, brk;
    logic [4:0] fc3;
`endif

    int         sel;
    logic       tx_s, rdy_s, busy_s;
    logic [4:0] fc_s;
    logic [7:0] sb [$];
    int         errors = 0;
    int         checks = 0;

    uart_frame_tx #(.DIV_INT(P_DIVI[0]), .DIV_FRAC(P_DIVF[0]), .MSB_FIRST(P_MSB[0]),
                    .PARITY(P_PAR[0]), .STOP_BITS(P_STOP[0]), .GAP_CYCLES(P_GAP[0])) u0 (
        .CLK(CLK), .RST(RST), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy0), .en(en[0]),
`ifdef UART_FRAME_TX_BREAK_EN
        .break_req(1'b0),
`endif
        .UART_TX(tx0), .busy(busy0), .fifo_count(fc0));

    uart_frame_tx #(.FIFO_AW(2), .DIV_INT(P_DIVI[1]), .DIV_FRAC(P_DIVF[1]), .MSB_FIRST(P_MSB[1]),
                    .PARITY(P_PAR[1]), .STOP_BITS(P_STOP[1]), .GAP_CYCLES(P_GAP[1])) u1 (
        .CLK(CLK), .RST(RST), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy1), .en(en[1]),
`ifdef UART_FRAME_TX_BREAK_EN
        .break_req(1'b0),
`endif
        .UART_TX(tx1), .busy(busy1), .fifo_count(fc1));

    uart_frame_tx #(.DIV_INT(P_DIVI[2]), .DIV_FRAC(P_DIVF[2]), .MSB_FIRST(P_MSB[2]),
                    .PARITY(P_PAR[2]), .STOP_BITS(P_STOP[2]), .GAP_CYCLES(P_GAP[2])) u2 (
        .CLK(CLK), .RST(RST), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy2), .en(en[2]),
`ifdef UART_FRAME_TX_BREAK_EN
        .break_req(1'b0),
`endif
        .UART_TX(tx2), .busy(busy2), .fifo_count(fc2));

`ifdef UART_FRAME_TX_BREAK_EN
    uart_frame_tx #(.DIV_INT(P_DIVI[3]), .DIV_FRAC(P_DIVF[3]), .MSB_FIRST(P_MSB[3]),
                    .PARITY(P_PAR[3]), .STOP_BITS(P_STOP[3]), .GAP_CYCLES(P_GAP[3])) u3 (
        .CLK(CLK), .RST(RST), .in_data(din[3]), .in_valid(vld[3]), .in_ready(rdy3), .en(en[3]),
        .break_req(brk), .UART_TX(tx3), .busy(busy3), .fifo_count(fc3));
`endif

    always_comb begin
        tx_s   = 1'b1;
        rdy_s  = 1'b0;
        busy_s = 1'b0;
        fc_s   = '0;
        case (sel)
            0: begin tx_s = tx0; rdy_s = rdy0; busy_s = busy0; fc_s = fc0; end
            1: begin tx_s = tx1; rdy_s = rdy1; busy_s = busy1; fc_s = {2'b00, fc1}; end
            2: begin tx_s = tx2; rdy_s = rdy2; busy_s = busy2; fc_s = fc2; end
`ifdef UART_FRAME_TX_BREAK_EN
            3: begin tx_s = tx3; rdy_s = rdy3; busy_s = busy3; fc_s = fc3; end
`endif
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic acc);
        @(negedge CLK);
        chk($sformatf("in_ready[u%0d]", sel), rdy_s, acc);
        din[sel] = d;
        vld[sel] = 1'b1;
        if (acc) sb.push_back(d);
        @(negedge CLK);
        vld[sel] = 1'b0;
    endtask

    // Waits for a start bit, then checks every clock of the frame against a model.
    task automatic check_frame(input int exp_idle);
        logic [7:0] d;
        logic       eb [16];
        logic       obs, v;
        int         nb, idle, guard, acc, sum, per;
        bit         first;
        idle = 0;
        guard = 0;
        obs = 1'b0;
        @(negedge CLK);
        while (tx_s !== 1'b0 && guard < 20000) begin
            idle++;
            guard++;
            @(negedge CLK);
        end
        if (tx_s !== 1'b0) begin
            chk($sformatf("start_timeout[u%0d]", sel), tx_s, 0);
            return;
        end
        if (exp_idle >= 0) chk($sformatf("idle_clocks[u%0d]", sel), idle, exp_idle);
        chk($sformatf("busy_in_frame[u%0d]", sel), busy_s, 1);
        if (sb.size() != 0) d = sb.pop_front();
        else d = 8'hxx;
        eb[0] = 1'b0;
        for (int j = 0; j < 8; j++) eb[1+j] = (P_MSB[sel] != 0) ? d[7-j] : d[j];
        nb = 9;
        if (P_PAR[sel] != 0) begin
            eb[nb] = (^d) ^ (P_PAR[sel] == 2);
            nb++;
        end
        for (int j = 0; j < P_STOP[sel]; j++) begin
            eb[nb] = 1'b1;
            nb++;
        end
        acc = 0;
        first = 1'b1;
        for (int b = 0; b < nb; b++) begin
            sum = acc + P_DIVF[sel];
            per = P_DIVI[sel] + sum / 16;
            acc = sum % 16;
            for (int c = 0; c < per; c++) begin
                if (!first) @(negedge CLK);
                first = 1'b0;
                v = tx_s;
                if (c == 0) obs = v;
                else if (v !== obs) obs = 1'bx;
            end
            chk($sformatf("u%0d_d%02h_bit%0d", sel, d, b), obs, eb[b]);
        end
        @(negedge CLK);
        chk($sformatf("line_after_stop[u%0d]", sel), tx_s, 1);
        chk($sformatf("busy_after_stop[u%0d]", sel), busy_s, P_GAP[sel] > 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            din[i] = '0;
            vld[i] = 1'b0;
            en[i]  = 1'b0;
        end
`ifdef UART_FRAME_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        for (int i = 0; i < NI; i++) begin
            sel = i;
            #1;
            chk($sformatf("rst_tx[u%0d]", i), tx_s, 1);
            chk($sformatf("rst_busy[u%0d]", i), busy_s, 0);
            chk($sformatf("rst_ready[u%0d]", i), rdy_s, 1);
            chk($sformatf("rst_count[u%0d]", i), fc_s, 0);
        end
        @(negedge CLK);
        RST = 1'b0;

        // Default format, single word: start one clock after acceptance.
        sel = 0;
        en[0] = 1'b1;
        push(8'hA5, 1'b1);
        chk("count_after_push", fc_s, 1);
        chk("tx_before_start", tx_s, 1);
        check_frame(0);

        // LSB first, even parity, two stop bits.
        sel = 1;
        en[1] = 1'b1;
        push(8'hA5, 1'b1);
        check_frame(0);

        // LSB first, odd parity, 3-clock gap.
        sel = 2;
        en[2] = 1'b1;
        push(8'hA5, 1'b1);
        check_frame(0);

        // Two queued words: gap clocks plus one idle clock between frames.
        en[2] = 1'b0;
        push(8'h5A, 1'b1);
        push(8'hC3, 1'b1);
        @(negedge CLK);
        en[2] = 1'b1;
        check_frame(0);
        check_frame(P_GAP[2]);

        // Four-entry FIFO filled while disabled; fifth word refused.
        sel = 1;
        en[1] = 1'b0;
        push(8'h01, 1'b1);
        push(8'h80, 1'b1);
        push(8'h7E, 1'b1);
        push(8'hF0, 1'b1);
        push(8'hFF, 1'b0);
        chk("full_count", fc_s, 4);
        chk("full_ready", rdy_s, 0);
        @(negedge CLK);
        en[1] = 1'b1;
        @(posedge CLK);
        #1;
        chk("ready_after_pop", rdy_s, 1);
        chk("count_after_pop", fc_s, 3);
        check_frame(0);
        check_frame(0);
        check_frame(0);
        check_frame(0);
        chk("fifo_drained", fc_s, 0);

`ifdef UART_FRAME_TX_BREAK_EN
        // Break takes priority over the queued word, then the word is sent.
        sel = 3;
        en[3] = 1'b0;
        push(8'h96, 1'b1);
        @(negedge CLK);
        brk = 1'b1;
        en[3] = 1'b1;
        @(negedge CLK);
        brk = 1'b0;
        chk("busy_in_break", busy_s, 1);
        n = 0;
        guard = 0;
        while (tx_s === 1'b0 && guard < 20000) begin
            n++;
            guard++;
            @(negedge CLK);
        end
        chk("break_low_clocks", n, 2 * 10 * P_DIVI[3] + (2 * 10 * P_DIVF[3]) / 16);
        check_frame(0);
`endif

        // Asynchronous reset in the middle of a data bit with words queued.
        sel = 0;
        en[0] = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        chk("queued_count", fc_s, 3);
        @(negedge CLK);
        en[0] = 1'b1;
        repeat (815) @(negedge CLK);
        chk("busy_before_rst", busy_s, 1);
        chk("tx_before_rst", tx_s, 0);
        chk("count_before_rst", fc_s, 2);
        #2;
        RST = 1'b1;
        #1;
        chk("tx_on_rst", tx_s, 1);
        chk("count_on_rst", fc_s, 0);
        chk("busy_on_rst", busy_s, 0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        push(8'hC3, 1'b1);
        check_frame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
